// File: rtl/loop_index_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : loop_index_sequencer
// Purpose  : Walks a two-level nested loop (outer over filters, inner over
//            nonzeros) and emits one (outer, inner) index pair per
//            valid/ready transfer. Also drives the reset/step strobes of a
//            downstream inclusive-max wrap counter so that its count tracks
//            inner_idx_o in every RUN cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          : clock, rising edge
//   rst_n_i        : asynchronous active-low reset
//   start_i        : launch request, sampled only in IDLE
//   inner_max_i    : inclusive last inner index, latched at start
//   outer_max_i    : inclusive last outer index, latched at start
//   ready_i        : downstream accepts current index pair
//   abort_i        : (LOOP_SEQ_ABORT_EN only) abandon the run from RUN
//   valid_o        : index pair valid (RUN)
//   inner_idx_o    : current inner index
//   outer_idx_o    : current outer index
//   last_inner_o   : inner index at latched max while valid
//   last_o         : both indices at latched max while valid
//   counter_rst_o  : downstream counter reset (IDLE/DONE)
//   counter_ld_o   : downstream counter step (valid & ready)
//   busy_o         : high in RUN
//   done_o         : one-cycle completion pulse
// Configuration
//   LOOP_SEQ_ABORT_EN : when defined, adds abort_i
// ============================================================================
module loop_index_sequencer #(
  parameter int INNER_WIDTH = 4,
  parameter int OUTER_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic [INNER_WIDTH-1:0] inner_max_i,
  input  logic [OUTER_WIDTH-1:0] outer_max_i,
  input  logic                   ready_i,
`ifdef LOOP_SEQ_ABORT_EN
  input  logic                   abort_i,
`endif
  output logic                   valid_o,
  output logic [INNER_WIDTH-1:0] inner_idx_o,
  output logic [OUTER_WIDTH-1:0] outer_idx_o,
  output logic                   last_inner_o,
  output logic                   last_o,
  output logic                   counter_rst_o,
  output logic                   counter_ld_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam logic [INNER_WIDTH-1:0] C_INNER_ONE = INNER_WIDTH'(1);
  localparam logic [OUTER_WIDTH-1:0] C_OUTER_ONE = OUTER_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                 state_q;
  logic [INNER_WIDTH-1:0] inner_q;
  logic [OUTER_WIDTH-1:0] outer_q;
  logic [INNER_WIDTH-1:0] inner_max_q;
  logic [OUTER_WIDTH-1:0] outer_max_q;

  logic                   inner_wrap;
  logic                   at_last;
  logic                   abort_req;
  logic [INNER_WIDTH-1:0] inner_d;
  logic [OUTER_WIDTH-1:0] outer_d;

  assign inner_wrap = (inner_q == inner_max_q);
  assign at_last    = inner_wrap && (outer_q == outer_max_q);

`ifdef LOOP_SEQ_ABORT_EN
  assign abort_req = abort_i;
`else
  assign abort_req = 1'b0;
`endif

  // Index step for one transfer: inner counts up to its inclusive max, then
  // wraps and carries into outer.
  always_comb begin
    inner_d = inner_q + C_INNER_ONE;
    outer_d = outer_q;
    if (inner_wrap) begin
      inner_d = '0;
      outer_d = outer_q + C_OUTER_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      inner_q     <= '0;
      outer_q     <= '0;
      inner_max_q <= '0;
      outer_max_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            inner_max_q <= inner_max_i;
            outer_max_q <= outer_max_i;
            inner_q     <= '0;
            outer_q     <= '0;
            state_q     <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort_req) begin
            // Abort wins over any concurrent transfer: indices are zeroed
            // and no completion pulse is produced.
            inner_q <= '0;
            outer_q <= '0;
            state_q <= S_IDLE;
          end else if (ready_i) begin
            if (at_last) begin
              // Final pair stays on the outputs; only the state advances.
              state_q <= S_DONE;
            end else begin
              inner_q <= inner_d;
              outer_q <= outer_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // All outputs except counter_ld_o are decoded from registers only, so the
  // asynchronous reset reaches them without waiting for an edge.
  assign valid_o       = (state_q == S_RUN);
  assign busy_o        = (state_q == S_RUN);
  assign done_o        = (state_q == S_DONE);
  assign counter_rst_o = (state_q != S_RUN);
  assign counter_ld_o  = valid_o & ready_i;
  assign inner_idx_o   = inner_q;
  assign outer_idx_o   = outer_q;
  assign last_inner_o  = valid_o & inner_wrap;
  assign last_o        = valid_o & at_last;

endmodule
`default_nettype wire

// File: tb/tb_loop_index_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_loop_index_sequencer
// Purpose  : Directed self-checking bench for loop_index_sequencer: reset,
//            free-running loop, backpressure with a downstream wrap counter
//            model, degenerate loop, ignored restart, mid-run reset and
//            (with LOOP_SEQ_ABORT_EN) abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loop_index_sequencer;

  localparam int IW = 4;
  localparam int OW = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b1;
  logic          start_i = 1'b0;
  logic [IW-1:0] inner_max_i = '0;
  logic [OW-1:0] outer_max_i = '0;
  logic          ready_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          valid_o;
  logic [IW-1:0] inner_idx_o;
  logic [OW-1:0] outer_idx_o;
  logic          last_inner_o;
  logic          last_o;
  logic          counter_rst_o;
  logic          counter_ld_o;
  logic          busy_o;
  logic          done_o;

  int n_checks = 0;
  int n_fail   = 0;

  loop_index_sequencer #(.INNER_WIDTH(IW), .OUTER_WIDTH(OW)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .start_i       (start_i),
    .inner_max_i   (inner_max_i),
    .outer_max_i   (outer_max_i),
    .ready_i       (ready_i),
`ifdef LOOP_SEQ_ABORT_EN
    .abort_i       (abort_i),
`endif
    .valid_o       (valid_o),
    .inner_idx_o   (inner_idx_o),
    .outer_idx_o   (outer_idx_o),
    .last_inner_o  (last_inner_o),
    .last_o        (last_o),
    .counter_rst_o (counter_rst_o),
    .counter_ld_o  (counter_ld_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Downstream inclusive-max wrap counter, as the sequencer's consumer sees it.
  logic [IW-1:0] ctr_max = '0;
  logic [IW-1:0] ctr = '0;
  always @(posedge clk_i) begin
    if (counter_rst_o)     ctr <= '0;
    else if (counter_ld_o) ctr <= (ctr == ctr_max) ? '0 : ctr + IW'(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  // Launch a run: start_i sampled at the next edge, returns in cycle 1.
  task automatic launch(input int imax, input int omax);
    inner_max_i = IW'(imax);
    outer_max_i = OW'(omax);
    ctr_max     = IW'(imax);
    start_i     = 1'b1;
    step();
    start_i     = 1'b0;
  endtask

  logic [31:0] pat;
  int          xfers;
  bit          seen_done;
  bit          stalled;
  logic [IW-1:0] prev_in;
  logic [OW-1:0] prev_out;
  logic          prev_li;

  initial begin
    // ---------------- reset ----------------
    #3 rst_n_i = 1'b0;
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_crst", counter_rst_o, 1);
    check("rst_inner", inner_idx_o, 0);
    check("rst_outer", outer_idx_o, 0);
    step(); step();
    rst_n_i = 1'b1;
    step();

    // ---------------- free-running loop ----------------
    ready_i = 1'b1;
    launch(2, 1);
    for (int c = 1; c <= 6; c++) begin
      #1;
      check("free_valid", valid_o, 1);
      check("free_outer", outer_idx_o, (c - 1) / 3);
      check("free_inner", inner_idx_o, (c - 1) % 3);
      check("free_last_inner", last_inner_o, (c == 3 || c == 6) ? 1 : 0);
      check("free_last", last_o, (c == 6) ? 1 : 0);
      check("free_ld", counter_ld_o, 1);
      check("free_ctr", ctr, inner_idx_o);
      step();
    end
    #1;
    check("free_done7", done_o, 1);
    check("free_valid7", valid_o, 0);
    check("free_crst7", counter_rst_o, 1);
    step();
    #1;
    check("free_done8", done_o, 0);
    check("free_busy8", busy_o, 0);
    check("free_crst8", counter_rst_o, 1);

    // ---------------- backpressure ----------------
    pat     = 32'hB36D_5AC7;
    ready_i = 1'b0;
    launch(2, 1);
    xfers = 0; seen_done = 0; stalled = 0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      ready_i = pat[c % 32];
      #1;
      if (done_o) begin
        seen_done = 1;
      end else if (valid_o) begin
        check("bp_ctr", ctr, inner_idx_o);
        if (stalled) begin
          check("bp_hold_inner", inner_idx_o, prev_in);
          check("bp_hold_outer", outer_idx_o, prev_out);
          check("bp_hold_li", last_inner_o, prev_li);
        end
        if (ready_i) begin
          check("bp_seq_inner", inner_idx_o, xfers % 3);
          check("bp_seq_outer", outer_idx_o, xfers / 3);
          xfers++;
          stalled = 0;
        end else begin
          stalled  = 1;
          prev_in  = inner_idx_o;
          prev_out = outer_idx_o;
          prev_li  = last_inner_o;
        end
      end
      if (!seen_done) step();
    end
    check("bp_done_seen", seen_done, 1);
    check("bp_xfers", xfers, 6);
    step();

    // ---------------- degenerate loop ----------------
    ready_i = 1'b1;
    launch(0, 0);
    #1;
    check("deg_valid", valid_o, 1);
    check("deg_last_inner", last_inner_o, 1);
    check("deg_last", last_o, 1);
    step();
    #1;
    check("deg_done", done_o, 1);
    check("deg_valid2", valid_o, 0);
    step();
    #1;
    check("deg_idle", busy_o, 0);

    // ---------------- ignored restart ----------------
    launch(2, 1);
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) begin
        start_i = 1'b1;
        inner_max_i = '0;
        outer_max_i = '0;
      end else begin
        start_i = 1'b0;
      end
      #1;
      check("rs_outer", outer_idx_o, (c - 1) / 3);
      check("rs_inner", inner_idx_o, (c - 1) % 3);
      check("rs_last", last_o, (c == 6) ? 1 : 0);
      step();
    end
    start_i = 1'b1;
    #1;
    check("rs_done", done_o, 1);
    step();
    start_i = 1'b0;
    #1;
    check("rs_idle_valid", valid_o, 0);
    step();
    #1;
    check("rs_no_second_run", valid_o, 0);

    // ---------------- reset mid-run ----------------
    launch(2, 1);
    step();
    #1;
    check("mr_pre_valid", valid_o, 1);
    rst_n_i = 1'b0;
    #1;
    check("mr_valid", valid_o, 0);
    check("mr_busy", busy_o, 0);
    check("mr_done", done_o, 0);
    check("mr_ld", counter_ld_o, 0);
    check("mr_crst", counter_rst_o, 1);
    check("mr_inner", inner_idx_o, 0);
    check("mr_outer", outer_idx_o, 0);
    step();
    rst_n_i = 1'b1;
    step();
    #1;
    check("mr_no_done", done_o, 0);

`ifdef LOOP_SEQ_ABORT_EN
    // ---------------- abort ----------------
    launch(3, 3);
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (outer_idx_o == 1 && inner_idx_o == 2) break;
      step();
    end
    check("ab_at_1_2", {outer_idx_o, inner_idx_o}, {8'd1, 4'd2});
    abort_i = 1'b1;
    #1;
    check("ab_ld", counter_ld_o, 1);
    step();
    abort_i = 1'b0;
    #1;
    check("ab_valid", valid_o, 0);
    check("ab_done", done_o, 0);
    check("ab_crst", counter_rst_o, 1);
    check("ab_inner", inner_idx_o, 0);
    check("ab_outer", outer_idx_o, 0);
    step();
    #1;
    check("ab_no_done", done_o, 0);
    launch(3, 3);
    #1;
    check("ab_restart_valid", valid_o, 1);
    check("ab_restart_idx", {outer_idx_o, inner_idx_o}, 12'h000);
    for (int c = 0; c < 30 && !seen_done; c++) begin
      step();
      #1;
      if (done_o) seen_done = 1;
    end
    check("ab_restart_done", seen_done, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/loop_index_sequencer.md
# loop_index_sequencer

- Upstream control stage for the inclusive-max wrap counters in the accelerator datapath.
- Walks a two-level nested loop and emits one (outer, inner) index pair per valid/ready transfer.
- Drives the reset and load strobes of a downstream wrap counter so that its count mirrors `inner_idx_o`.
- Used for sparse weight/tile stepping: the inner loop runs over nonzeros, the outer loop over filters.

## Interface
- `INNER_WIDTH`, default 4: width of the inner index and of `inner_max_i`.
- `OUTER_WIDTH`, default 8: width of the outer index and of `outer_max_i`.
- `clk_i`, input, 1: single clock; all logic is on its rising edge.
- `rst_n_i`, input, 1: asynchronous, active-low reset.
- `start_i`, input, 1: launch request; sampled only in IDLE.
- `inner_max_i`, input, INNER_WIDTH: inclusive last inner index; latched at start.
- `outer_max_i`, input, OUTER_WIDTH: inclusive last outer index; latched at start.
- `ready_i`, input, 1: downstream accepts the current index.
- `valid_o`, output, 1: index pair valid.
- `inner_idx_o`, output, INNER_WIDTH: current inner index.
- `outer_idx_o`, output, OUTER_WIDTH: current outer index.
- `last_inner_o`, output, 1: `inner_idx_o == latched inner_max` while `valid_o`.
- `last_o`, output, 1: both indices at their latched max while `valid_o`.
- `counter_rst_o`, output, 1: reset strobe for the downstream wrap counter.
- `counter_ld_o`, output, 1: step strobe for the downstream wrap counter.
- `busy_o`, output, 1: high in RUN.
- `done_o`, output, 1: one-cycle completion pulse.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE:**
  - A sampled `start_i` latches both max inputs, zeroes both indices and moves to RUN.
  - With `start_i` low, the FSM stays in IDLE.
- **RUN:**
  - `valid_o` is 1.
  - A transfer is `valid_o & ready_i`.
  - On each transfer, if inner < inner_max then inner increments by 1.
  - Otherwise inner goes to 0 and outer increments by 1.
  - On the transfer where `last_o` is high, the FSM moves to DONE and the indices are not advanced.
- **DONE:** lasts exactly one cycle; `done_o` is 1; next state is IDLE.
- Total transfers per run = (inner_max+1)*(outer_max+1).
- Both max values are inclusive; max = 0 gives a single iteration at that level.
- Index arithmetic is unsigned at native width; no overflow is possible within the latched bounds.
- The latched max values are unaffected by changes on the max inputs during RUN.
- `start_i` is ignored in RUN and DONE; there is no queueing.
- While `valid_o & !ready_i`, all of `inner_idx_o`, `outer_idx_o`, `last_inner_o` and `last_o` hold stable.
- `counter_rst_o` = 1 in IDLE and DONE, 0 in RUN; it is decoded from the state register and has no combinational input path.
- `counter_ld_o` = `valid_o & ready_i`, a combinational path from `ready_i`.
- Downstream contract: a wrap counter driven with max = inner_max, reset by `counter_rst_o` and stepped by `counter_ld_o` holds `inner_idx_o` in every RUN cycle.

## Timing
- Reset values while `rst_n_i` is low:
  - FSM state is IDLE.
  - `valid_o`, `busy_o`, `done_o`, `counter_ld_o`, `last_o` and `last_inner_o` are 0.
  - Both indices and both latched max registers are 0.
  - `counter_rst_o` is 1.
- Outputs take these values asynchronously, not at the next edge.
- Start latency: `start_i` sampled at edge N gives `valid_o` = 1 with index (0,0) in cycle N+1.
- Throughput: one transfer per cycle while `ready_i` is held high.
- Completion: the last transfer at edge M gives `done_o` in cycle M+1 and IDLE in cycle M+2.
- The earliest restart is a `start_i` sampled at edge M+2.
- Reset asserted mid-RUN forces `valid_o` low immediately; no `done_o` is produced.

## Configuration
- Macro: `LOOP_SEQ_ABORT_EN`.
- When defined:
  - Adds input port `abort_i` (1 bit).
  - In RUN, a sampled `abort_i` moves the FSM to IDLE on the next edge and zeroes both indices.
  - The abort produces no `done_o` pulse.
  - A transfer occurring in the abort cycle still counts downstream, because `counter_ld_o` is still asserted in that cycle.
  - `abort_i` is ignored in IDLE and DONE.
- When not defined: the port does not exist, and every run ends only through DONE or reset.

## Test plan
- **Reset:** hold `rst_n_i` low mid-RUN → `valid_o`, `busy_o`, `done_o` and `counter_ld_o` drop to 0 and `counter_rst_o` rises to 1 without waiting for a clock edge; both indices read 0.
- **Free-running loop:**
  - Stimulus: inner_max=2, outer_max=1, `ready_i`=1, `start_i` sampled at cycle 0.
  - Response:
    - `valid_o` is high in cycles 1–6 with (outer,inner) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
    - `last_inner_o` is high in cycles 3 and 6; `last_o` is high in cycle 6.
    - `done_o` is high in cycle 7; IDLE in cycle 8.
- **Backpressure:**
  - Stimulus: same maxes, `ready_i` toggling pseudo-randomly.
  - Response:
    - Indices stay stable while stalled.
    - Exactly 6 transfers occur.
    - A downstream wrap counter model stays equal to `inner_idx_o` in every RUN cycle.
- **Degenerate loop:** inner_max=0, outer_max=0 → one transfer with `last_inner_o`=`last_o`=1; `done_o` one cycle after that transfer.
- **Ignored restart:** pulse `start_i` during RUN and during DONE, and change the max inputs during RUN → the sequence is unchanged and there is no second run.
- **Abort (`LOOP_SEQ_ABORT_EN` defined):**
  - Stimulus: inner_max=3, outer_max=3; assert `abort_i` at index (1,2).
  - Response: IDLE on the next cycle, no `done_o`, `counter_rst_o`=1; a fresh start then restarts at (0,0).
